acc_cpu_core: RTL
=================

// Module: acc_cpu_core
// PURPOSE
//  Parametrised multi-cycle accumulator CPU: A/B registers, Z/C flags, 16-op ISA, scratch RAM.
//  - Fetches from an external synchronous instruction memory, so the program is no longer baked into the core.
//  - Adds a fetch/exec FSM, stall enable, HALT, and correct carry/borrow/zero semantics.
//  - Sits between the board-level ROM block and the debug display; debug outputs mirror internal state.
// PARAMETERS
//  DATA_W  8   width of A, B, RAM words, immediates
//  PC_W    10  program counter width; PC_W >= DATA_W required (elaboration-time check)
//  RAM_AW  4   scratch RAM address bits; depth = 2**RAM_AW
//  IW      14  instruction width, fixed = 4 + PC_W; opcode = ir[IW-1 -: 4], operand = ir[PC_W-1:0]
// PORTS
//  clk        in   1       single clock; all state on posedge
//  rst        in   1       synchronous, active-high reset
//  en         in   1       1 = advance FSM; 0 = hold all state
//  imem_addr  out  PC_W    instruction address (registered)
//  imem_data  in   IW      instruction word, valid 1 cycle after imem_addr
//  halted     out  1       1 while in HALT state
//  a_out      out  DATA_W  A register
//  b_out      out  DATA_W  B register
//  pc_out     out  PC_W    PC
//  ir_out     out  IW      IR
//  z_out      out  1       zero flag
//  c_out      out  1       carry/borrow flag
// BEHAVIOUR
//  Reset (rst=1 at posedge): PC=0, A=B=0, IR=0, Z=C=0, imem_addr=0, state=FETCH, halted=0.
//  - RAM contents are not reset. rst dominates en and aborts any in-flight instruction.
//  FSM: FETCH -> WAIT -> EXEC -> FETCH; 3 cycles per instruction when en=1 throughout.
//  - FETCH: imem_addr<=PC.
//  - WAIT: IR<=imem_data; PC<=PC+1 (wraps 2**PC_W-1 -> 0).
//  - EXEC: execute IR; jump taken overwrites the incremented PC.
//  - HALT: absorbing until rst.
//  en=0: every register and state holds; imem_addr holds. en honoured in every state.
//  Opcodes (opr = operand; imm = opr[DATA_W-1:0]; ra = opr[RAM_AW-1:0]):
//   0000 NOP; if opr == all-ones: HLT -> HALT
//   0001 MVB B<=imm      1010 MVA A<=imm      0010 LD A<=RAM[ra]    0011 ST RAM[ra]<=A
//   0100 XCHG A<->B      0101 JMP PC<=opr     0110 JZ  0111 JC  1000 JNZ  1001 JNC (PC<=opr if cond)
//   1011 AND  1100 OR  1101 NOT(A<=~A)  1110 ADD A<=A+B  1111 SUB A<=A-B
//  Arithmetic: computed at DATA_W+1 bits.
//  - ADD: C=bit DATA_W of sum.
//  - SUB: C=1 iff A<B unsigned (borrow).
//  Z rules:
//  - AND/OR/NOT/ADD/SUB: Z=(new A==0).
//  - AND/OR/NOT leave C unchanged.
//  - MVA/MVB/LD/ST/XCHG/jumps/NOP leave Z and C unchanged.
//  Flag use: conditional jumps use flags as of EXEC entry; results write A and flags in the same EXEC edge.
//  LD reads RAM combinationally in EXEC; ST followed by LD to the same ra returns the stored value.
//  Jump to current PC (self-loop) is legal; ra ignores upper operand bits.
// STRUCTURE
//  cpu_pkg: opcode localparams, FSM state encoding (FETCH/WAIT/EXEC/HALT), HLT operand rule.
//  Sub-module acc_cpu_alu: combinational; op, A, B, C_in -> result, Z, C.
//  - FSM, PC, IR, RAM and register file stay in acc_cpu_core.
// TESTING
//  1 Reset: rst=1 2 cycles -> all outputs 0, halted=0; release -> imem_addr 0,1,2 at 3-cycle spacing.
//  2 MVA 255; MVB 1; ADD -> A=0, Z=1, C=1; then MVB 1; SUB -> A=255, Z=0, C=1.
//  3 MVA 5; ST 3; MVA 0; LD 3 -> A=5; AND with B=0 -> Z=1, C unchanged.
//  4 JZ 40 with Z=0 -> PC=next; with Z=1 -> next fetch at 40; JMP 1023 then NOP -> PC wraps to 0.
//  5 en=0 for 5 cycles mid-WAIT -> no state change; resume completes the instruction identically.
//  6 HLT -> halted=1, PC frozen 10 cycles; rst mid-EXEC of ADD -> A=0, no flag update.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU.
// Contents:
//   - opcode encodings (4-bit field at the top of each instruction word)
//   - FSM state encoding for the fetch/wait/exec/halt sequencer
//   - is_hlt(): recognises the halt form of the NOP opcode
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;  // NOP, or HLT when the operand is all-ones
  localparam logic [3:0] OP_MVB  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_XCHG = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JC   = 4'h7;
  localparam logic [3:0] OP_JNZ  = 4'h8;
  localparam logic [3:0] OP_JNC  = 4'h9;
  localparam logic [3:0] OP_MVA  = 4'hA;
  localparam logic [3:0] OP_AND  = 4'hB;
  localparam logic [3:0] OP_OR   = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_ADD  = 4'hE;
  localparam logic [3:0] OP_SUB  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // The caller reduces its operand with &opr so this stays width-independent.
  function automatic logic is_hlt(input logic [3:0] op, input logic opr_all_ones);
    return (op == OP_NOP) && opr_all_ones;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU.
// Ports:
//   op     in  4       opcode of the instruction in EXEC
//   a, b   in  DATA_W  accumulator and B register
//   c_in   in  1       current carry flag (passed through for AND/OR/NOT)
//   res    out DATA_W  new accumulator value (only meaningful when wr=1)
//   z, c   out 1       new flags (only meaningful when wr=1)
//   wr     out 1       1 for AND/OR/NOT/ADD/SUB: result and flags are committed
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] res,
  output logic              z,
  output logic              c,
  output logic              wr
);

  // One extra bit catches the carry on ADD and the borrow on SUB:
  // {0,a}-{0,b} has its top bit set exactly when a < b unsigned.
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    res  = a;
    c    = c_in;
    wr   = 1'b0;
    case (op)
      OP_AND: begin res = a & b; wr = 1'b1; end
      OP_OR:  begin res = a | b; wr = 1'b1; end
      OP_NOT: begin res = ~a;    wr = 1'b1; end
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[DATA_W-1:0];
        c    = wide[DATA_W];
        wr   = 1'b1;
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[DATA_W-1:0];
        c    = wide[DATA_W];
        wr   = 1'b1;
      end
      default: ;
    endcase
    z = (res == '0);
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU fetching from an external instruction memory.
// Ports:
//   clk        in   1       clock, all state on posedge
//   rst        in   1       synchronous active-high reset (dominates en)
//   en         in   1       1 = advance, 0 = hold every register
//   imem_addr  out  PC_W    registered instruction address
//   imem_data  in   IW      instruction word for imem_addr
//   halted     out  1       high while in the HALT state
//   a_out      out  DATA_W  A register
//   b_out      out  DATA_W  B register
//   pc_out     out  PC_W    program counter
//   ir_out     out  IW      instruction register
//   z_out      out  1       zero flag
//   c_out      out  1       carry/borrow flag
//
// Instruction memory contract: imem_addr is loaded in FETCH; the memory must
// present the word for that address on imem_data by the end of the following
// (WAIT) cycle, where it is captured into IR. There is no valid/ready pair:
// the core always waits exactly one cycle, and en=0 simply stretches it.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 10,
  parameter int RAM_AW = 4,
  parameter int IW     = 4 + PC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [IW-1:0]     imem_data,
  output logic              halted,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [IW-1:0]     ir_out,
  output logic              z_out,
  output logic              c_out
);

  // Immediates are cut from the operand field, so it must be at least as wide.
  if (PC_W < DATA_W) begin : g_pcw_check
    $error("acc_cpu_core: PC_W must be >= DATA_W");
  end
  if (IW != 4 + PC_W) begin : g_iw_check
    $error("acc_cpu_core: IW must equal 4 + PC_W");
  end

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     addr_q;
  logic [IW-1:0]       ir_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                z_q, c_q;
  logic [DATA_W-1:0]   ram [2**RAM_AW];

  // Instruction fields, always decoded from IR.
  logic [3:0]          op;
  logic [PC_W-1:0]     opr;
  logic [DATA_W-1:0]   imm;
  logic [RAM_AW-1:0]   ra;
  logic                hlt;
  logic                jump_taken;

  assign op  = ir_q[IW-1 -: 4];
  assign opr = ir_q[PC_W-1:0];
  assign imm = opr[DATA_W-1:0];
  assign ra  = opr[RAM_AW-1:0];
  assign hlt = is_hlt(op, &opr);

  // Conditions see the flags as they stand on entry to EXEC.
  always_comb begin
    jump_taken = 1'b0;
    case (op)
      OP_JMP: jump_taken = 1'b1;
      OP_JZ:  jump_taken = z_q;
      OP_JC:  jump_taken = c_q;
      OP_JNZ: jump_taken = ~z_q;
      OP_JNC: jump_taken = ~c_q;
      default: jump_taken = 1'b0;
    endcase
  end

  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c, alu_wr;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (op),
    .a    (a_q),
    .b    (b_q),
    .c_in (c_q),
    .res  (alu_res),
    .z    (alu_z),
    .c    (alu_c),
    .wr   (alu_wr)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_EXEC;
        ST_EXEC:  state_d = hlt ? ST_HALT : ST_FETCH;
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      addr_q <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_FETCH: addr_q <= pc_q;
        ST_WAIT: begin
          ir_q <= imem_data;
          pc_q <= pc_q + PC_W'(1);
        end
        ST_EXEC: begin
          // The increment happened in WAIT; a taken jump replaces it.
          if (jump_taken) pc_q <= opr;
          case (op)
            OP_MVA:  a_q <= imm;
            OP_MVB:  b_q <= imm;
            OP_LD:   a_q <= ram[ra];
            OP_XCHG: begin
              a_q <= b_q;
              b_q <= a_q;
            end
            default: begin
              if (alu_wr) begin
                a_q <= alu_res;
                z_q <= alu_z;
                c_q <= alu_c;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Scratch RAM is deliberately not reset; a reset cycle only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && en && (state_q == ST_EXEC) && (op == OP_ST)) begin
      ram[ra] <= a_q;
    end
  end

  assign imem_addr = addr_q;
  assign halted    = (state_q == ST_HALT);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign z_out     = z_q;
  assign c_out     = c_q;

endmodule
